driver_74lv595_chain: RTL and testbench



---
 rtl/driver_74lv595_chain.sv | 176 +++++++++++++++++
 tb/tb_driver_74lv595_chain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_74lv595_chain.sv
// driver_74lv595_chain: serialises CHANNELS frames of BITS bits into parallel
// 74LV595 daisy-chains that share one SRCLK/RCLK pair.
// Optional macro DRIVER_74LV595_OE_EN adds the OE_n output, which keeps the
// 595 outputs blanked from reset until the first complete frame is latched.
module driver_74lv595_chain #(
  parameter int CHANNELS     = 2,
  parameter int BITS         = 32,
  parameter int DIV          = 1,
  parameter int MSB_FIRST    = 1,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [CHANNELS*BITS-1:0] data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     SRCLK,
  output logic                     RCLK,
  output logic [CHANNELS-1:0]      SER
`ifdef DRIVER_74LV595_OE_EN
  ,
  output logic                     OE_n
`endif
);

  localparam int CW = $clog2(DIV + 1);
  localparam int BW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [CW-1:0]                  r_div, w_div_nxt;
  logic                           r_half, w_half_nxt;
  logic [BW-1:0]                  r_bit, w_bit_nxt;
  logic [CHANNELS-1:0][BITS-1:0]  r_shreg, w_shreg_nxt;

  logic                           r_load_ready, w_load_ready_nxt;
  logic                           r_busy, w_busy_nxt;
  logic                           r_frame_done, w_frame_done_nxt;
  logic                           r_srclk, w_srclk_nxt;
  logic                           r_rclk, w_rclk_nxt;
  logic [CHANNELS-1:0]            r_ser, w_ser_nxt;

  logic                           w_start;
  logic                           w_half_end;

  assign w_start    = load_valid || (AUTO_REFRESH != 0);
  assign w_half_end = (r_div == CW'(DIV - 1));

  // Next-state, counter and shift logic; pin values are derived from the
  // next state so every output leaves the block straight from a flop.
  always_comb begin
    w_state_nxt      = r_state;
    w_div_nxt        = r_div;
    w_half_nxt       = r_half;
    w_bit_nxt        = r_bit;
    w_shreg_nxt      = r_shreg;
    w_frame_done_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SHIFT;
          w_div_nxt   = '0;
          w_half_nxt  = 1'b0;
          w_bit_nxt   = '0;
          w_shreg_nxt = data;
        end
      end
      ST_SHIFT: begin
        if (w_half_end) begin
          w_div_nxt = '0;
          if (!r_half) begin
            w_half_nxt = 1'b1;
          end else begin
            w_half_nxt = 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              if (MSB_FIRST != 0) w_shreg_nxt[c] = r_shreg[c] << 1;
              else                w_shreg_nxt[c] = r_shreg[c] >> 1;
            end
            if (r_bit == BW'(BITS - 1)) begin
              w_state_nxt = ST_LATCH;
              w_bit_nxt   = '0;
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end
        end else begin
          w_div_nxt = r_div + CW'(1);
        end
      end
      ST_LATCH: begin
        if (w_half_end) begin
          w_div_nxt = '0;
          if (!r_half) begin
            w_half_nxt = 1'b1;
          end else begin
            w_half_nxt       = 1'b0;
            w_state_nxt      = ST_IDLE;
            w_frame_done_nxt = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_load_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_srclk_nxt      = (w_state_nxt == ST_SHIFT) && w_half_nxt;
    w_rclk_nxt       = (w_state_nxt == ST_LATCH) && w_half_nxt;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_ser_nxt[c] = (w_state_nxt == ST_SHIFT) &&
                     ((MSB_FIRST != 0) ? w_shreg_nxt[c][BITS-1] : w_shreg_nxt[c][0]);
    end
  end

  // State, counters, shift registers and registered pin drivers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_half       <= 1'b0;
      r_bit        <= '0;
      r_shreg      <= '0;
      r_load_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_srclk      <= 1'b0;
      r_rclk       <= 1'b0;
      r_ser        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_half       <= w_half_nxt;
      r_bit        <= w_bit_nxt;
      r_shreg      <= w_shreg_nxt;
      r_load_ready <= w_load_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_srclk      <= w_srclk_nxt;
      r_rclk       <= w_rclk_nxt;
      r_ser        <= w_ser_nxt;
    end
  end

  assign load_ready = r_load_ready;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign SRCLK      = r_srclk;
  assign RCLK       = r_rclk;
  assign SER        = r_ser;

`ifdef DRIVER_74LV595_OE_EN
  logic r_oe_n;

  // Blank the chain outputs until a full frame has been latched after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_oe_n <= 1'b1;
    end else if (w_frame_done_nxt) begin
      r_oe_n <= 1'b0;
    end
  end

  assign OE_n = r_oe_n;
`endif

endmodule

// File: tb/tb_driver_74lv595_chain.sv
// Scoreboard bench for driver_74lv595_chain: three instances (MSB-first DIV=1,
// LSB-first DIV=3, auto-refresh DIV=1), each CHANNELS=2, BITS=8.
module tb_driver_74lv595_chain;

  typedef struct packed {
    logic [7:0] s0;
    logic [7:0] s1;
  } exp_t;

  localparam int DIVS [3] = '{1, 3, 1};

  logic        clk = 1'b0;
  logic [2:0]  rstn = '1;
  logic [2:0]  lvalid = '0;
  logic [15:0] din [3];
  logic [2:0]  lready, busy, fdone, srclk, rclk;
  logic [1:0]  ser [3];
`ifdef DRIVER_74LV595_OE_EN
  logic [2:0]  oe_n;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  driver_74lv595_chain #(.CHANNELS(2), .BITS(8), .DIV(1), .MSB_FIRST(1), .AUTO_REFRESH(0)) u_a (
    .clk(clk), .resetn(rstn[0]), .data(din[0]), .load_valid(lvalid[0]),
    .load_ready(lready[0]), .busy(busy[0]), .frame_done(fdone[0]),
    .SRCLK(srclk[0]), .RCLK(rclk[0]), .SER(ser[0])
`ifdef DRIVER_74LV595_OE_EN
    , .OE_n(oe_n[0])
`endif
  );

  driver_74lv595_chain #(.CHANNELS(2), .BITS(8), .DIV(3), .MSB_FIRST(0), .AUTO_REFRESH(0)) u_b (
    .clk(clk), .resetn(rstn[1]), .data(din[1]), .load_valid(lvalid[1]),
    .load_ready(lready[1]), .busy(busy[1]), .frame_done(fdone[1]),
    .SRCLK(srclk[1]), .RCLK(rclk[1]), .SER(ser[1])
`ifdef DRIVER_74LV595_OE_EN
    , .OE_n(oe_n[1])
`endif
  );

  driver_74lv595_chain #(.CHANNELS(2), .BITS(8), .DIV(1), .MSB_FIRST(1), .AUTO_REFRESH(1)) u_c (
    .clk(clk), .resetn(rstn[2]), .data(din[2]), .load_valid(lvalid[2]),
    .load_ready(lready[2]), .busy(busy[2]), .frame_done(fdone[2]),
    .SRCLK(srclk[2]), .RCLK(rclk[2]), .SER(ser[2])
`ifdef DRIVER_74LV595_OE_EN
    , .OE_n(oe_n[2])
`endif
  );

  task automatic chk(input int k, input string nm, input int unsigned act, input int unsigned want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0d expected %0d", k, nm, act, want);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor state, one slot per instance.
  int         hs [3];
  int         nrise [3];
  int         nrclk [3];
  int         hi_len [3];
  int         last_done [3];
  logic [7:0] acc0 [3];
  logic [7:0] acc1 [3];
  logic [1:0] ser_rise [3];
  logic       seen [3];
  logic [2:0] p_srclk = '0, p_rclk = '0, p_fdone = '0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      hs[k] = 0; nrise[k] = 0; nrclk[k] = 0; hi_len[k] = 0; last_done[k] = -1;
      acc0[k] = '0; acc1[k] = '0; ser_rise[k] = '0; seen[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rstn[k]) begin
          nrise[k] = 0; nrclk[k] = 0; hi_len[k] = 0; last_done[k] = -1;
          acc0[k] = '0; acc1[k] = '0; seen[k] = 1'b0;
          p_srclk[k] = 1'b0; p_rclk[k] = 1'b0; p_fdone[k] = 1'b0;
        end else begin
          exp_t e;
          chk(k, "rdy_vs_busy", lready[k], !busy[k]);
          if (srclk[k] && !p_srclk[k]) begin
            acc0[k] = {acc0[k][6:0], ser[k][0]};
            acc1[k] = {acc1[k][6:0], ser[k][1]};
            nrise[k]++;
            hi_len[k] = 1;
            ser_rise[k] = ser[k];
          end else if (srclk[k]) begin
            hi_len[k]++;
            chk(k, "ser_stable", ser[k], ser_rise[k]);
          end else if (p_srclk[k]) begin
            chk(k, "srclk_high_len", hi_len[k], DIVS[k]);
          end
          if (rclk[k] && !p_rclk[k]) begin
            nrclk[k]++;
            chk(k, "rclk_while_srclk", srclk[k], 0);
          end
          if (fdone[k]) begin
            chk(k, "done_width", p_fdone[k], 0);
            seen[k] = 1'b1;
            if (qsize(k) == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL u%0d unexpected_frame: got frame_done expected none", k);
            end else begin
              e = pop(k);
              chk(k, "ser0_bits", acc0[k], e.s0);
              chk(k, "ser1_bits", acc1[k], e.s1);
              chk(k, "srclk_rises", nrise[k], 8);
              chk(k, "rclk_rises", nrclk[k], 1);
              chk(k, "latency", cyc - hs[k], 18 * DIVS[k]);
              if (k == 2 && last_done[k] >= 0) chk(k, "auto_interval", cyc - last_done[k], 19);
              last_done[k] = cyc;
            end
            nrise[k] = 0; nrclk[k] = 0; acc0[k] = '0; acc1[k] = '0;
          end
`ifdef DRIVER_74LV595_OE_EN
          chk(k, "oe_n", oe_n[k], !seen[k]);
`endif
          if (lready[k] && (lvalid[k] || k == 2)) hs[k] = cyc + 1;
          p_srclk[k] = srclk[k]; p_rclk[k] = rclk[k]; p_fdone[k] = fdone[k];
        end
      end
    end
  end

  task automatic wait_rdy(input int k);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!lready[k] && t < 500);
    if (!lready[k]) begin
      n_cmp++; n_fail++;
      $display("FAIL u%0d ready_timeout: got load_ready=0 expected 1 within 500 cycles", k);
    end
  endtask

  task automatic wait_done(input int k);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!fdone[k] && t < 500);
    if (!fdone[k]) begin
      n_cmp++; n_fail++;
      $display("FAIL u%0d done_timeout: got frame_done=0 expected 1 within 500 cycles", k);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] e0, input logic [7:0] e1);
    exp_t e;
    e.s0 = e0; e.s1 = e1;
    @(posedge clk); #1;
    push(k, e);
    din[k] = {d1, d0};
    lvalid[k] = 1'b1;
    wait_rdy(k);
    @(posedge clk); #1;
    lvalid[k] = 1'b0;
    wait_done(k);
  endtask

  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) din[k] = '0;
    #1 rstn = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk(k, "rst_load_ready", lready[k], 1);
      chk(k, "rst_busy", busy[k], 0);
      chk(k, "rst_frame_done", fdone[k], 0);
      chk(k, "rst_srclk", srclk[k], 0);
      chk(k, "rst_rclk", rclk[k], 0);
      chk(k, "rst_ser", ser[k], 0);
`ifdef DRIVER_74LV595_OE_EN
      chk(k, "rst_oe_n", oe_n[k], 1);
`endif
    end
    repeat (2) @(posedge clk);
    #1 rstn[1:0] = 2'b11;

    // MSB-first, DIV=1
    send(0, 8'hA5, 8'h3C, 8'hA5, 8'h3C);
    send(0, 8'hFF, 8'h00, 8'hFF, 8'h00);
    send(0, 8'h80, 8'h01, 8'h80, 8'h01);

    // Asynchronous reset during bit slot 3; this frame is never expected
    @(posedge clk); #1;
    din[0] = 16'hFFFF;
    lvalid[0] = 1'b1;
    wait_rdy(0);
    @(posedge clk); #1;
    lvalid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk(0, "mid_srclk", srclk[0], 1);
    chk(0, "mid_ser", ser[0], 3);
    #2 rstn[0] = 1'b0;
    #1;
    chk(0, "arst_srclk", srclk[0], 0);
    chk(0, "arst_rclk", rclk[0], 0);
    chk(0, "arst_ser", ser[0], 0);
    chk(0, "arst_busy", busy[0], 0);
    chk(0, "arst_load_ready", lready[0], 1);
    repeat (3) begin
      @(negedge clk);
      chk(0, "arst_hold_rclk", rclk[0], 0);
    end
    @(posedge clk); #1 rstn[0] = 1'b1;
    send(0, 8'h5A, 8'hC3, 8'h5A, 8'hC3);

    // LSB-first, DIV=3: expected words are in shift order (bit 0 first)
    send(1, 8'hA5, 8'h3C, 8'hA5, 8'h3C);
    e.s0 = 8'h80; e.s1 = 8'h3C; push(1, e);
    e.s0 = 8'h48; e.s1 = 8'h0F; push(1, e);
    @(posedge clk); #1;
    din[1] = {8'h3C, 8'h01};
    lvalid[1] = 1'b1;
    wait_rdy(1);
    @(posedge clk); #1;
    din[1] = {8'hF0, 8'h12};
    wait_done(1);
    @(posedge clk); #1;
    chk(1, "restart_busy", busy[1], 1);
    lvalid[1] = 1'b0;
    wait_done(1);

    // Auto-refresh: data change mid-frame lands in the following frame only
    din[2] = {8'h0F, 8'h96};
    e.s0 = 8'h96; e.s1 = 8'h0F; push(2, e);
    @(posedge clk); #1 rstn[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1 din[2] = {8'h55, 8'hE1};
    e.s0 = 8'hE1; e.s1 = 8'h55; push(2, e);
    wait_done(2);
    wait_done(2);
    #1 rstn[2] = 1'b0;

    repeat (4) @(posedge clk);
    for (int k = 0; k < 3; k++) chk(k, "sb_drained", qsize(k), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
